// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline sequencing controller: FSM state encodings,
// the decoded control bundle, and the RUN-state decode helpers.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    PCTRL_RUN      = 2'd0,
    PCTRL_EX_HOLD  = 2'd1,
    PCTRL_BUS_WAIT = 2'd2,
    PCTRL_REDIRECT = 2'd3
  } pctrl_state_e;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  typedef struct packed {
    logic        jump_en;
    logic [31:0] jump_addr;
    logic        hold_pc;
    logic        hold_if_id;
    logic        hold_id_ex;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic        timeout;
  } pctrl_out_t;

  // RUN priority: direct jump, deferred jump, EX hold, bus wait, idle.
  function automatic pctrl_state_e pctrl_run_next(input logic jump, input logic bus,
                                                  input logic hold);
    pctrl_state_e s;
    if (jump && !bus) s = PCTRL_RUN;
    else if (jump)    s = PCTRL_REDIRECT;
    else if (hold)    s = PCTRL_EX_HOLD;
    else if (bus)     s = PCTRL_BUS_WAIT;
    else              s = PCTRL_RUN;
    return s;
  endfunction

  function automatic pctrl_out_t pctrl_run_out(input logic jump, input logic [31:0] addr,
                                               input logic bus, input logic hold);
    pctrl_out_t o;
    o = '0;
    if (jump && !bus) begin
      o.jump_en     = 1'b1;
      o.jump_addr   = addr;
      o.flush_if_id = 1'b1;
      o.flush_id_ex = 1'b1;
    end else if (jump) begin
      o.hold_pc     = 1'b1;
      o.flush_if_id = 1'b1;
      o.flush_id_ex = 1'b1;
    end else if (hold || bus) begin
      o.hold_pc    = 1'b1;
      o.hold_if_id = 1'b1;
      o.hold_id_ex = 1'b1;
    end else begin
      o = '0;
    end
    return o;
  endfunction

endpackage

// File: rtl/pipe_ctrl_perf.sv
// Performance counters for pipe_ctrl: stall cycles (PC frozen) and issued
// redirects. Both are free-running 32-bit counters that wrap to 0.
module pipe_ctrl_perf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_stall,
  input  logic        i_redirect,
  output logic [31:0] o_stall_cnt,
  output logic [31:0] o_redirect_cnt
);

  logic [31:0] r_stall_cnt;
  logic [31:0] r_redirect_cnt;

  // Count stall and redirect cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt    <= 32'd0;
      r_redirect_cnt <= 32'd0;
    end else begin
      if (i_stall)    r_stall_cnt    <= r_stall_cnt + 32'd1;
      if (i_redirect) r_redirect_cnt <= r_redirect_cnt + 32'd1;
    end
  end

  assign o_stall_cnt    = r_stall_cnt;
  assign o_redirect_cnt = r_redirect_cnt;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: PC redirect plus hold/flush of pc_reg, if_id
// and id_ex, with deferred redirects and an EX hold watchdog. Perf counters
// are built only when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int HOLD_MAX = 64,
  parameter int CNT_W    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_flag_i,
  input  logic        bus_hold_i,
  output logic        jump_en_o,
  output logic [31:0] jump_addr_o,
  output logic        hold_pc_o,
  output logic        hold_if_id_o,
  output logic        hold_id_ex_o,
  output logic        flush_if_id_o,
  output logic        flush_id_ex_o,
  output logic        hold_timeout_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] redirect_cnt_o
);

  localparam logic [CNT_W-1:0] HCNT_LAST = CNT_W'(HOLD_MAX - 1);
  localparam logic [CNT_W-1:0] HCNT_ONE  = CNT_W'(1);

  pctrl_state_e     r_state, w_state_nxt;
  logic [31:0]      r_pend_addr, w_pend_nxt;
  logic [CNT_W-1:0] r_hcnt, w_hcnt_nxt;
  logic             w_as_run;
  pctrl_out_t       w_out;

  // State, pending redirect target and watchdog count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= PCTRL_RUN;
      r_pend_addr <= 32'd0;
      r_hcnt      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pend_addr <= w_pend_nxt;
      r_hcnt      <= w_hcnt_nxt;
    end
  end

  // EX_HOLD without a hold request and BUS_WAIT with the bus free act as RUN.
  always_comb begin
    case (r_state)
      PCTRL_RUN:      w_as_run = 1'b1;
      PCTRL_EX_HOLD:  w_as_run = !hold_flag_i;
      PCTRL_BUS_WAIT: w_as_run = !bus_hold_i;
      PCTRL_REDIRECT: w_as_run = 1'b0;
      default:        w_as_run = 1'b1;
    endcase
  end

  // Next-state, pending-address and watchdog-count decode.
  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend_addr;
    w_hcnt_nxt  = r_hcnt;
    if (w_as_run) begin
      w_state_nxt = pctrl_run_next(jump_en_i, bus_hold_i, hold_flag_i);
      if (jump_en_i && bus_hold_i) w_pend_nxt = jump_addr_i;
      else if (!jump_en_i && hold_flag_i) w_hcnt_nxt = HCNT_ONE;
      else w_pend_nxt = r_pend_addr;
    end else begin
      case (r_state)
        PCTRL_EX_HOLD: begin
          if (r_hcnt == HCNT_LAST) begin
            w_state_nxt = PCTRL_RUN;
            w_hcnt_nxt  = '0;
          end else begin
            w_hcnt_nxt = r_hcnt + HCNT_ONE;
          end
        end
        PCTRL_BUS_WAIT: begin
          if (jump_en_i) begin
            w_pend_nxt  = jump_addr_i;
            w_state_nxt = PCTRL_REDIRECT;
          end else begin
            w_state_nxt = PCTRL_BUS_WAIT;
          end
        end
        PCTRL_REDIRECT: begin
          // The youngest redirect overwrites any older pending one.
          if (bus_hold_i && jump_en_i) w_pend_nxt = jump_addr_i;
          else if (!bus_hold_i) w_state_nxt = PCTRL_RUN;
          else w_pend_nxt = r_pend_addr;
        end
        default: w_state_nxt = PCTRL_RUN;
      endcase
    end
  end

  // Mealy output decode.
  always_comb begin
    w_out = '0;
    if (w_as_run) begin
      w_out = pctrl_run_out(jump_en_i, jump_addr_i, bus_hold_i, hold_flag_i);
    end else begin
      case (r_state)
        PCTRL_EX_HOLD: begin
          if (r_hcnt == HCNT_LAST) begin
            w_out.timeout     = 1'b1;
            w_out.flush_id_ex = 1'b1;
          end else begin
            w_out.hold_pc    = 1'b1;
            w_out.hold_if_id = 1'b1;
            w_out.hold_id_ex = 1'b1;
          end
        end
        PCTRL_BUS_WAIT: begin
          w_out.hold_pc     = 1'b1;
          w_out.hold_if_id  = 1'b1;
          w_out.hold_id_ex  = 1'b1;
          w_out.flush_if_id = jump_en_i;
          w_out.flush_id_ex = jump_en_i;
        end
        PCTRL_REDIRECT: begin
          w_out.flush_if_id = 1'b1;
          w_out.flush_id_ex = 1'b1;
          if (bus_hold_i) begin
            w_out.hold_pc = 1'b1;
          end else begin
            w_out.jump_en   = 1'b1;
            w_out.jump_addr = r_pend_addr;
          end
        end
        default: w_out = '0;
      endcase
    end
  end

  // Outputs are forced quiet during reset; a flush overrides a hold on the same register.
  assign jump_en_o      = rst_n & w_out.jump_en;
  assign jump_addr_o    = rst_n ? w_out.jump_addr : 32'd0;
  assign hold_pc_o      = rst_n & w_out.hold_pc;
  assign hold_if_id_o   = rst_n & w_out.hold_if_id & ~w_out.flush_if_id;
  assign hold_id_ex_o   = rst_n & w_out.hold_id_ex & ~w_out.flush_id_ex;
  assign flush_if_id_o  = rst_n & w_out.flush_if_id;
  assign flush_id_ex_o  = rst_n & w_out.flush_id_ex;
  assign hold_timeout_o = rst_n & w_out.timeout;

`ifdef PIPE_CTRL_PERF_EN
  pipe_ctrl_perf u_perf (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_stall       (hold_pc_o),
    .i_redirect    (jump_en_o),
    .o_stall_cnt   (stall_cnt_o),
    .o_redirect_cnt(redirect_cnt_o)
  );
`else
  assign stall_cnt_o    = 32'd0;
  assign redirect_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl (HOLD_MAX=4): the driver queues the expected
// output bundle per cycle, a negedge monitor pops and compares.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        jump_en_i = 1'b0;
  logic [31:0] jump_addr_i = 32'd0;
  logic        hold_flag_i = 1'b0;
  logic        bus_hold_i = 1'b0;
  logic        jump_en_o, hold_pc_o, hold_if_id_o, hold_id_ex_o;
  logic        flush_if_id_o, flush_id_ex_o, hold_timeout_o;
  logic [31:0] jump_addr_o, stall_cnt_o, redirect_cnt_o;

  pipe_ctrl #(.HOLD_MAX(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
    .hold_flag_i(hold_flag_i), .bus_hold_i(bus_hold_i), .jump_en_o(jump_en_o),
    .jump_addr_o(jump_addr_o), .hold_pc_o(hold_pc_o), .hold_if_id_o(hold_if_id_o),
    .hold_id_ex_o(hold_id_ex_o), .flush_if_id_o(flush_if_id_o),
    .flush_id_ex_o(flush_id_ex_o), .hold_timeout_o(hold_timeout_o),
    .stall_cnt_o(stall_cnt_o), .redirect_cnt_o(redirect_cnt_o)
  );

  always #5 clk = ~clk;

  // Bundle order: jump_en, jump_addr, hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex, timeout
  localparam logic [38:0] V_Z     = 39'd0;
  localparam logic [38:0] V_HOLD3 = {1'b0, 32'd0, 6'b111000};
  localparam logic [38:0] V_PCFL  = {1'b0, 32'd0, 6'b100110};
  localparam logic [38:0] V_TO    = {1'b0, 32'd0, 6'b000011};

  function automatic logic [38:0] v_jump(input logic [31:0] a);
    return {1'b1, a, 6'b000110};
  endfunction

  typedef struct {
    string       name;
    logic [38:0] vec;
    logic        chk_cnt;
    logic [31:0] stall;
    logic [31:0] redir;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_stall = 32'd0;
  logic [31:0] exp_redir = 32'd0;

  wire [38:0] act = {jump_en_o, jump_addr_o, hold_pc_o, hold_if_id_o, hold_id_ex_o,
                     flush_if_id_o, flush_id_ex_o, hold_timeout_o};

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_cmp++;
      if (act !== e.vec) begin
        n_bad++;
        $display("FAIL %s: outputs got %h expected %h", e.name, act, e.vec);
      end
      if (e.chk_cnt) begin
        n_cmp++;
        if (stall_cnt_o !== e.stall || redirect_cnt_o !== e.redir) begin
          n_bad++;
          $display("FAIL %s_cnt: stall/redirect got %0d/%0d expected %0d/%0d",
                   e.name, stall_cnt_o, redirect_cnt_o, e.stall, e.redir);
        end
      end
    end
  end

  task automatic step(input string nm, input logic rst, input logic je,
                      input logic [31:0] ad, input logic hf, input logic bh,
                      input logic [38:0] ev, input logic cc = 1'b0);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rst; jump_en_i = je; jump_addr_i = ad; hold_flag_i = hf; bus_hold_i = bh;
    e.name = nm; e.vec = ev; e.chk_cnt = cc; e.stall = exp_stall; e.redir = exp_redir;
    q.push_back(e);
  endtask

  initial begin
    // Reset: outputs quiet even with a jump request present
    step("reset", 1'b0, 1'b1, 32'h100, 1'b0, 1'b0, V_Z, 1'b1);
    step("idle", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, V_Z);
    // Direct redirect
    step("direct", 1'b1, 1'b1, 32'h100, 1'b0, 1'b0, v_jump(32'h100));
    step("direct_after", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, V_Z);
    // Redirect captured during bus wait
    step("defer_c1", 1'b1, 1'b1, 32'h200, 1'b0, 1'b1, V_PCFL);
    step("defer_c2", 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, V_PCFL);
    step("defer_c3", 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, V_PCFL);
    step("defer_c4", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, v_jump(32'h200));
    step("defer_c5", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, V_Z);
    // Youngest redirect wins
    step("young_c1", 1'b1, 1'b1, 32'h250, 1'b0, 1'b1, V_PCFL);
    step("young_c2", 1'b1, 1'b1, 32'h300, 1'b0, 1'b1, V_PCFL);
    step("young_c3", 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, V_PCFL);
    step("young_c4", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, v_jump(32'h300));
    step("young_c5", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, V_Z);
    // BUS_WAIT, then a jump captured there
    step("bw_c1", 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, V_HOLD3);
    step("bw_c2", 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, V_HOLD3);
    step("bw_jump", 1'b1, 1'b1, 32'h280, 1'b0, 1'b1, V_PCFL);
    step("bw_replay", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, v_jump(32'h280));
    step("bw_hold", 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, V_HOLD3);
    step("bw_release", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, V_Z);
    // Watchdog: 3 hold cycles then timeout, re-entry, jump ignored in EX_HOLD
    step("wd_c1", 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, V_HOLD3);
    step("wd_c2", 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, V_HOLD3);
    step("wd_c3", 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, V_HOLD3);
    step("wd_timeout", 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, V_TO);
    step("wd_reenter", 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, V_HOLD3);
    step("wd_jump_ign", 1'b1, 1'b1, 32'h500, 1'b1, 1'b0, V_HOLD3);
    step("wd_exit", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, V_Z);
    step("exh_c1", 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, V_HOLD3);
    step("exh_jump", 1'b1, 1'b1, 32'h600, 1'b0, 1'b0, v_jump(32'h600));
    step("prio_c1", 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, V_HOLD3);
    step("prio_c2", 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, V_HOLD3);
    step("prio_c3", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, V_Z);
    // Perf counters from a clean reset: 5 stall cycles, 2 redirects
    exp_stall = 32'd0; exp_redir = 32'd0;
    step("perf_rst", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, V_Z, 1'b1);
    for (int i = 0; i < 5; i++) step("perf_stall", 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, V_HOLD3);
    step("perf_free", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, V_Z);
    step("perf_j1", 1'b1, 1'b1, 32'h700, 1'b0, 1'b0, v_jump(32'h700));
    step("perf_j2", 1'b1, 1'b1, 32'h704, 1'b0, 1'b0, v_jump(32'h704));
`ifdef PIPE_CTRL_PERF_EN
    exp_stall = 32'd5; exp_redir = 32'd2;
`endif
    step("perf_chk", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, V_Z, 1'b1);
    // Reset mid-operation discards the pending redirect
    exp_stall = 32'd0; exp_redir = 32'd0;
    step("rstmid_cap", 1'b1, 1'b1, 32'h400, 1'b0, 1'b1, V_PCFL);
    step("rstmid_rst", 1'b0, 1'b1, 32'h400, 1'b0, 1'b1, V_Z, 1'b1);
    step("rstmid_rel", 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, V_HOLD3);
    for (int i = 0; i < 3; i++) step("rstmid_nojump", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, V_Z);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
